// File: rtl/cpu_oam_dma_pkg.sv
// Shared sprite-DMA definitions: FSM state encoding and default bus addresses.
package cpu_oam_dma_pkg;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

  localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_bus_mux.sv
// Selects the CPU or the DMA engine as the driver of the system bus.
module cpu_bus_mux (
  input  logic        dma_active,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        dma_rw,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        bus_rw,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata
);

  assign bus_rw    = dma_active ? dma_rw    : cpu_rw;
  assign bus_addr  = dma_active ? dma_addr  : cpu_addr;
  assign bus_wdata = dma_active ? dma_wdata : cpu_wdata;

endmodule

// File: rtl/cpu_oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR stalls the CPU and copies page $PP00-$PPFF to TARGET_ADDR.
// Define CPU_OAM_DMA_ALIGN_EN to add the parity counter and the odd-cycle ALIGN state.
module cpu_oam_dma
  import cpu_oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_ADDR,
  parameter logic [15:0] TARGET_ADDR  = OAM_DATA_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        ready,
  output logic        bus_rw,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_index
);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  latch;
  logic        dma_rw;
  logic [15:0] dma_addr;
`ifdef CPU_OAM_DMA_ALIGN_EN
  logic        parity;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      dma_active <= 1'b0;
      dma_index  <= 8'h00;
      page       <= 8'h00;
      latch      <= 8'h00;
`ifdef CPU_OAM_DMA_ALIGN_EN
      parity     <= 1'b0;
`endif
    end else begin
`ifdef CPU_OAM_DMA_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: begin
          // The trigger write itself still reaches the bus through the mux this cycle.
          if (ready && !cpu_rw && cpu_addr == TRIGGER_ADDR) begin
            page       <= cpu_wdata;
            state      <= HALT;
            ready      <= 1'b0;
            dma_active <= 1'b1;
          end
        end
        HALT: begin
`ifdef CPU_OAM_DMA_ALIGN_EN
          state <= parity ? ALIGN : READ;
`else
          state <= READ;
`endif
        end
`ifdef CPU_OAM_DMA_ALIGN_EN
        ALIGN: state <= READ;
`endif
        READ: begin
          latch <= bus_rdata;
          state <= WRITE;
        end
        WRITE: begin
          dma_index <= dma_index + 8'd1;
          if (dma_index == 8'hFF) begin
            state      <= IDLE;
            ready      <= 1'b1;
            dma_active <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // HALT/ALIGN park the bus as a read of whatever address the stalled CPU holds.
  always_comb begin
    dma_rw   = 1'b1;
    dma_addr = cpu_addr;
    case (state)
      READ:    dma_addr = {page, dma_index};
      WRITE: begin
        dma_rw   = 1'b0;
        dma_addr = TARGET_ADDR;
      end
      default: ;
    endcase
  end

  cpu_bus_mux u_bus_mux (
    .dma_active (dma_active),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dma_rw     (dma_rw),
    .dma_addr   (dma_addr),
    .dma_wdata  (latch),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata)
  );

endmodule
